// File: rtl/updown_counter_pkg.sv
// -----------------------------------------------------------------------------
// updown_counter_pkg
// Shared constants for the parameterised up/down counter:
//   - dir_e         : direction encoding on the dir port (DIR_UP=1, DIR_DOWN=0)
//   - DEFAULT_WIDTH : default counter width
//   - MIN_WIDTH / MAX_WIDTH : legal width range, checked at elaboration
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

package updown_counter_pkg;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  localparam int DEFAULT_WIDTH = 4;
  localparam int MIN_WIDTH     = 2;
  localparam int MAX_WIDTH     = 32;

endpackage : updown_counter_pkg

// File: rtl/updown_next_calc.sv
// -----------------------------------------------------------------------------
// updown_next_calc
// Purely combinational next-value and terminal-event logic for the counter.
// Holds no state; the registers live in param_updown_counter.
//
// Build option:
//   PARAM_UPDOWN_COUNTER_SAT_EN defined   -> saturate at 0 / MAX_VAL
//   PARAM_UPDOWN_COUNTER_SAT_EN undefined -> wrap modulo MAX_VAL+1
//
// Ports:
//   q        in  WIDTH  current registered count
//   en       in  1      count enable
//   dir      in  1      1 = up, 0 = down
//   load     in  1      parallel load (has priority over en)
//   load_val in  WIDTH  value to load, clamped to MAX_VAL
//   next_q   out WIDTH  count for the next edge
//   tc_next  out 1      terminal event for the next edge
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module updown_next_calc
  import updown_counter_pkg::*;
#(
  parameter int          WIDTH   = DEFAULT_WIDTH,
  parameter int unsigned MAX_VAL = 32'((64'd1 << WIDTH) - 64'd1)
) (
  input  logic [WIDTH-1:0] q,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] next_q,
  output logic             tc_next
);

  localparam logic [WIDTH-1:0] MAX_Q = MAX_VAL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ONE_Q = WIDTH'(1);

  // NOTE: every output gets a default at the top of the block, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    next_q  = q;
    tc_next = 1'b0;

    if (load) begin
      next_q = (load_val > MAX_Q) ? MAX_Q : load_val;
    end else if (en) begin
      if (dir == DIR_UP) begin
        if (q == MAX_Q) begin
          tc_next = 1'b1;
`ifdef PARAM_UPDOWN_COUNTER_SAT_EN
          next_q  = q;
`else
          next_q  = '0;
`endif
        end else begin
          next_q = q + ONE_Q;
        end
      end else begin
        if (q == '0) begin
          tc_next = 1'b1;
`ifdef PARAM_UPDOWN_COUNTER_SAT_EN
          next_q  = q;
`else
          next_q  = MAX_Q;
`endif
        end else begin
          next_q = q - ONE_Q;
        end
      end
    end
  end

endmodule : updown_next_calc

// File: rtl/param_updown_counter.sv
// -----------------------------------------------------------------------------
// param_updown_counter
// Parameterised up/down counter with modulus MAX_VAL+1, synchronous parallel
// load (clamped to MAX_VAL), registered terminal-event pulse and registered
// at_max / at_zero flags that are cycle-aligned with q.
//
// Build option:
//   PARAM_UPDOWN_COUNTER_SAT_EN defined   -> saturate mode
//   PARAM_UPDOWN_COUNTER_SAT_EN undefined -> wrap mode (default)
//
// Parameters:
//   WIDTH    counter width, 2..32
//   MAX_VAL  terminal count, 1..2**WIDTH-1
//
// Ports:
//   clk      in  1      rising-edge clock
//   rst_n    in  1      synchronous active-low reset
//   en       in  1      count enable
//   dir      in  1      1 = up, 0 = down
//   load     in  1      synchronous parallel load
//   load_val in  WIDTH  load value
//   q        out WIDTH  registered count
//   tc       out 1      registered terminal-event pulse
//   at_max   out 1      registered, high while q == MAX_VAL
//   at_zero  out 1      registered, high while q == 0
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module param_updown_counter
  import updown_counter_pkg::*;
#(
  parameter int          WIDTH   = DEFAULT_WIDTH,
  parameter int unsigned MAX_VAL = 32'((64'd1 << WIDTH) - 64'd1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             at_max,
  output logic             at_zero
);

  // Elaboration-time legality checks.
  if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("param_updown_counter: WIDTH must be in %0d..%0d", MIN_WIDTH, MAX_WIDTH);
  end
  if (MAX_VAL < 1 || 64'(MAX_VAL) > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_max
    $error("param_updown_counter: MAX_VAL must be in 1..2**WIDTH-1");
  end

  localparam logic [WIDTH-1:0] MAX_Q = MAX_VAL[WIDTH-1:0];

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             tc_q, tc_d;
  logic             at_max_q, at_max_d;
  logic             at_zero_q, at_zero_d;
  logic [WIDTH-1:0] calc_q;
  logic             calc_tc;

  updown_next_calc #(
    .WIDTH   (WIDTH),
    .MAX_VAL (MAX_VAL)
  ) u_next_calc (
    .q        (cnt_q),
    .en       (en),
    .dir      (dir),
    .load     (load),
    .load_val (load_val),
    .next_q   (calc_q),
    .tc_next  (calc_tc)
  );

  // Flags are decoded from the next-state value so they register on the same
  // edge as the count itself.
  always_comb begin
    cnt_d     = calc_q;
    tc_d      = calc_tc;
    at_max_d  = (calc_q == MAX_Q);
    at_zero_d = (calc_q == '0);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      tc_q      <= 1'b0;
      at_max_q  <= 1'b0;   // MAX_VAL >= 1 is enforced, so 0 is never MAX_VAL
      at_zero_q <= 1'b1;
    end else begin
      cnt_q     <= cnt_d;
      tc_q      <= tc_d;
      at_max_q  <= at_max_d;
      at_zero_q <= at_zero_d;
    end
  end

  assign q       = cnt_q;
  assign tc      = tc_q;
  assign at_max  = at_max_q;
  assign at_zero = at_zero_q;

endmodule : param_updown_counter

// File: tb/tb_param_updown_counter.sv
// -----------------------------------------------------------------------------
// tb_param_updown_counter
// Scoreboard bench for param_updown_counter (WIDTH=4, MAX_VAL=9). The driver
// applies one vector per cycle and pushes the reference model's expected
// outputs; an independent monitor pops and compares after each rising edge.
// Honours PARAM_UPDOWN_COUNTER_SAT_EN to select the expected mode.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_param_updown_counter;

  localparam int WIDTH = 4;
  localparam int MAXV  = 9;

  logic             clk = 1'b0;
  logic             rst_n, en, dir, load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] q;
  logic             tc, at_max, at_zero;

  typedef struct {
    string name;
    int    q;
    bit    tc;
    bit    at_max;
    bit    at_zero;
  } exp_t;

  exp_t exp_q[$];

  int vectors     = 0;
  int miscompares = 0;
  int model_cnt   = 0;   // reference count as a plain integer
  bit sat_mode;

  param_updown_counter #(
    .WIDTH   (WIDTH),
    .MAX_VAL (MAXV)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .dir      (dir),
    .load     (load),
    .load_val (load_val),
    .q        (q),
    .tc       (tc),
    .at_max   (at_max),
    .at_zero  (at_zero)
  );

  always #5 clk = ~clk;

  // Reference model: counting is arithmetic modulo MAXV+1 (wrap) or clipped
  // to [0, MAXV] (saturate); a terminal event is any step attempted past an end.
  task automatic apply(input string name, input bit r, input bit ld,
                       input int lv, input bit e, input bit d);
    exp_t x;
    bit   t;
    @(negedge clk);
    rst_n    = r;
    load     = ld;
    load_val = WIDTH'(lv);
    en       = e;
    dir      = d;
    t = 1'b0;
    if (!r) begin
      model_cnt = 0;
    end else if (ld) begin
      model_cnt = (lv > MAXV) ? MAXV : lv;
    end else if (e) begin
      if (d) begin
        t = (model_cnt == MAXV);
        if (sat_mode) model_cnt = (model_cnt + 1 > MAXV) ? MAXV : model_cnt + 1;
        else          model_cnt = (model_cnt + 1) % (MAXV + 1);
      end else begin
        t = (model_cnt == 0);
        if (sat_mode) model_cnt = (model_cnt - 1 < 0) ? 0 : model_cnt - 1;
        else          model_cnt = (model_cnt + MAXV) % (MAXV + 1);
      end
    end
    x.name    = name;
    x.q       = model_cnt;
    x.tc      = t;
    x.at_max  = (model_cnt == MAXV);
    x.at_zero = (model_cnt == 0);
    exp_q.push_back(x);
  endtask

  task automatic check(input exp_t x);
    vectors++;
    if (int'(q) !== x.q || tc !== x.tc || at_max !== x.at_max || at_zero !== x.at_zero) begin
      miscompares++;
      $display("FAIL %s: got q=%0d tc=%b at_max=%b at_zero=%b, expected q=%0d tc=%b at_max=%b at_zero=%b",
               x.name, q, tc, at_max, at_zero, x.q, x.tc, x.at_max, x.at_zero);
    end
  endtask

  // Monitor: each rising edge presents one output vector per pending entry.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        check(x);
      end
    end
  end

  initial begin
`ifdef PARAM_UPDOWN_COUNTER_SAT_EN
    sat_mode = 1'b1;
`else
    sat_mode = 1'b0;
`endif
    rst_n = 1'b1; en = 1'b0; dir = 1'b0; load = 1'b0; load_val = '0;

    // Reset overrides a simultaneous load.
    apply("reset_over_load", 1'b0, 1'b1, 5, 1'b1, 1'b1);

`ifndef PARAM_UPDOWN_COUNTER_SAT_EN
    // Up-wrap: 1..9 then 0 with tc.
    for (int i = 0; i < 10; i++) apply("up_wrap", 1'b1, 1'b0, 0, 1'b1, 1'b1);
    // Down-wrap: 0 -> 9 with tc, then 8.
    apply("down_wrap", 1'b1, 1'b0, 0, 1'b1, 1'b0);
    apply("down_after_wrap", 1'b1, 1'b0, 0, 1'b1, 1'b0);
`else
    apply("sat_load9", 1'b1, 1'b1, 9, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) apply("sat_up_blocked", 1'b1, 1'b0, 0, 1'b1, 1'b1);
    apply("sat_down", 1'b1, 1'b0, 0, 1'b1, 1'b0);
    apply("sat_load0", 1'b1, 1'b1, 0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) apply("sat_down_blocked", 1'b1, 1'b0, 0, 1'b1, 1'b0);
`endif

    // Load has priority over en and clamps to MAX_VAL; then hold.
    apply("load_clamp", 1'b1, 1'b1, 14, 1'b1, 1'b0);
    apply("hold", 1'b1, 1'b0, 0, 1'b0, 1'b1);
    apply("hold", 1'b1, 1'b0, 0, 1'b0, 1'b0);

    // Mid-count reset, then resume from 0.
    apply("load3", 1'b1, 1'b1, 3, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) apply("count_to_6", 1'b1, 1'b0, 0, 1'b1, 1'b1);
    apply("mid_reset", 1'b0, 1'b0, 0, 1'b1, 1'b1);
    apply("resume", 1'b1, 1'b0, 0, 1'b1, 1'b1);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      apply("random",
            ($urandom_range(0, 99) >= 3),
            ($urandom_range(0, 99) < 10),
            int'($urandom_range(0, 15)),
            ($urandom_range(0, 99) < 75),
            1'($urandom));
    end

    // Drain the scoreboard with a bounded wait.
    @(negedge clk);
    rst_n = 1'b1; load = 1'b0; en = 1'b0;
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected vectors never observed, required 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_param_updown_counter
